// File: rtl/cam_capture_ctrl.sv
// Camera capture sequencer: frame-aligned RGB565 byte pairing into RGB444
// pixels, written to the DP RAM port on the system clock.
module cam_capture_ctrl #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          continuous,
    input  logic          abort,
    input  logic          CAM_PCLK,
    input  logic          CAM_HREF,
    input  logic          CAM_VSYNC,
    input  logic [7:0]    CAM_px_data,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [11:0]   DP_RAM_data_in,
    output logic          DP_RAM_regW,
    output logic [2:0]    state,
    output logic          busy,
    output logic          frame_done,
    output logic [AW:0]   pix_count,
    output logic          ovf
);

    localparam logic [AW:0] TOTAL = (AW+1)'(IMG_W * IMG_H);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_VS  = 3'd1,
        WAIT_ACT = 3'd2,
        BYTE1    = 3'd3,
        BYTE2    = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t st, st_nx;

    logic [1:0] pclk_s, href_s, vs_s;
    logic [7:0] d_s1, d_s2;
    logic       pclk_d;
    logic       pclk_rise, href, vs;
    logic [6:0] b1;
    logic [AW:0] cnt;
    logic        pix_done;
    logic [11:0] pixel;

    // All camera signals pass through the same two stages so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_s <= '0;
            href_s <= '0;
            vs_s   <= '0;
            d_s1   <= '0;
            d_s2   <= '0;
            pclk_d <= 1'b0;
        end else begin
            pclk_s <= {pclk_s[0], CAM_PCLK};
            href_s <= {href_s[0], CAM_HREF};
            vs_s   <= {vs_s[0], CAM_VSYNC};
            d_s1   <= CAM_px_data;
            d_s2   <= d_s1;
            pclk_d <= pclk_s[1];
        end
    end

    assign pclk_rise = pclk_s[1] & ~pclk_d;
    assign href      = href_s[1];
    assign vs        = vs_s[1];

    assign pix_done = (st == BYTE2) & pclk_rise & ~vs & href;
    assign pixel    = {b1, d_s2[7], d_s2[4:1]};

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        if (abort) begin
            st_nx = IDLE;
        end else begin
            unique case (st)
                IDLE:     if (start | continuous) st_nx = WAIT_VS;
                WAIT_VS:  if (pclk_rise & vs) st_nx = WAIT_ACT;
                WAIT_ACT: if (pclk_rise & ~vs) st_nx = BYTE1;
                BYTE1: begin
                    if (pclk_rise) begin
                        if (vs)        st_nx = DONE;
                        else if (href) st_nx = BYTE2;
                    end
                end
                BYTE2: begin
                    if (pclk_rise) begin
                        if (vs) st_nx = DONE;
                        else    st_nx = BYTE1;
                    end
                end
                DONE:     st_nx = continuous ? WAIT_ACT : IDLE;
                default:  st_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            DP_RAM_regW    <= 1'b0;
            DP_RAM_addr_in <= '0;
            DP_RAM_data_in <= '0;
            cnt            <= '0;
            b1             <= '0;
            pix_count      <= '0;
            ovf            <= 1'b0;
        end else begin
            DP_RAM_regW <= 1'b0;
            if (!abort) begin
                if (st == IDLE && start)
                    ovf <= 1'b0;
                if (st == WAIT_ACT && pclk_rise && !vs)
                    cnt <= '0;
                if (st == BYTE1 && pclk_rise && !vs && href)
                    b1 <= {d_s2[7:4], d_s2[2:0]};
                // A full frame buffer drops pixels rather than wrapping
                if (pix_done) begin
                    if (cnt == TOTAL) begin
                        ovf <= 1'b1;
                    end else begin
                        DP_RAM_regW    <= 1'b1;
                        DP_RAM_addr_in <= cnt[AW-1:0];
                        DP_RAM_data_in <= pixel;
                        cnt            <= cnt + 1'b1;
                    end
                end
                if (st == DONE)
                    pix_count <= cnt;
            end
        end
    end

    assign state      = st;
    assign busy       = (st != IDLE);
    assign frame_done = (st == DONE);

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl: camera byte-stream model,
// expected-write queue and per-cycle output compare.
module tb_cam_capture_ctrl;

    localparam int W     = 16;
    localparam int H     = 8;
    localparam int AW    = 8;
    localparam int TOTAL = W * H;
    localparam int BLK   = 8;

    logic          clk = 1'b0;
    logic          rst, start, continuous, abort;
    logic          CAM_PCLK, CAM_HREF, CAM_VSYNC;
    logic [7:0]    CAM_px_data;
    logic [AW-1:0] DP_RAM_addr_in;
    logic [11:0]   DP_RAM_data_in;
    logic          DP_RAM_regW;
    logic [2:0]    state;
    logic          busy, frame_done, ovf;
    logic [AW:0]   pix_count;

    cam_capture_ctrl #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .abort(abort), .CAM_PCLK(CAM_PCLK), .CAM_HREF(CAM_HREF),
        .CAM_VSYNC(CAM_VSYNC), .CAM_px_data(CAM_px_data),
        .DP_RAM_addr_in(DP_RAM_addr_in), .DP_RAM_data_in(DP_RAM_data_in),
        .DP_RAM_regW(DP_RAM_regW), .state(state), .busy(busy),
        .frame_done(frame_done), .pix_count(pix_count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW+11:0] exp_q[$];
    logic [AW-1:0]  wa_log[$];
    logic [11:0]    wd_log[$];
    int  m_cnt;
    bit  m_ovf;
    bit  mon_en, check_en;
    int  wr_n, fd_cnt;
    logic [AW-1:0] last_addr, prev_a;
    logic [11:0]   prev_d;
    logic          prev_w;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    function automatic logic [11:0] mpix(logic [7:0] a, logic [7:0] b);
        return {a[7:4], a[2:0], b[7], b[4:1]};
    endfunction

    function automatic logic [7:0] gen(int kind, int i);
        if (kind == 1) return (i % 2 == 0) ? 8'hF0 : 8'h0F;
        if (kind == 2) return (i % 2 == 0) ? 8'h0F : 8'hF0;
        return 8'((i * 37 + kind * 11) ^ 8'h5A);
    endfunction

    // Per-cycle compare of DUT writes against the expected-write queue
    always @(negedge clk) begin
        if (mon_en) begin
            if (DP_RAM_regW) begin
                wr_n++;
                last_addr = DP_RAM_addr_in;
                wa_log.push_back(DP_RAM_addr_in);
                wd_log.push_back(DP_RAM_data_in);
                chk("strobe_width", 32'(prev_w), 32'd0);
                if (check_en) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'(DP_RAM_addr_in), 32'hFFFF);
                    end else begin
                        chk("write", 32'({DP_RAM_addr_in, DP_RAM_data_in}),
                            32'(exp_q.pop_front()));
                    end
                end
            end else begin
                chk("hold", 32'({DP_RAM_addr_in, DP_RAM_data_in}),
                    32'({prev_a, prev_d}));
            end
            if (frame_done) fd_cnt++;
            prev_w = DP_RAM_regW;
            prev_a = DP_RAM_addr_in;
            prev_d = DP_RAM_data_in;
        end
    end

    task automatic cam_byte(input logic [7:0] d, input logic h, input logic v);
        @(negedge clk);
        CAM_px_data = d;
        CAM_HREF    = h;
        CAM_VSYNC   = v;
        CAM_PCLK    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        CAM_PCLK = 1'b1;
        @(negedge clk);
    endtask

    task automatic vblank();
        repeat (2 * BLK) cam_byte(8'h00, 1'b0, 1'b1);
        repeat (2 * BLK) cam_byte(8'h00, 1'b0, 1'b0);
    endtask

    task automatic cam_line(input int n, input int kind, input bit cap);
        logic [7:0] d, prev;
        prev = 8'h00;
        for (int i = 0; i < n; i++) begin
            d = gen(kind, i);
            cam_byte(d, 1'b1, 1'b0);
            if (cap && (i % 2 == 1)) begin
                if (m_cnt < TOTAL) exp_q.push_back({AW'(m_cnt), mpix(prev, d)});
                else               m_ovf = 1'b1;
                if (m_cnt < TOTAL) m_cnt++;
            end
            prev = d;
        end
        repeat (4) cam_byte(8'h00, 1'b0, 1'b0);
    endtask

    task automatic lines(input int first, input int n, input bit cap);
        for (int l = first; l < first + n; l++)
            cam_line(2 * W, l + 3, cap);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_logs();
        wr_n = 0;
        fd_cnt = 0;
        wa_log.delete();
        wd_log.delete();
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic settle();
        repeat (20) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        CAM_PCLK = 1'b0; CAM_HREF = 1'b0; CAM_VSYNC = 1'b0; CAM_px_data = 8'h00;
        mon_en = 1'b0; check_en = 1'b1;
        prev_w = 1'b0; prev_a = '0; prev_d = '0;
        clear_logs();
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outs", 32'({DP_RAM_regW, busy, frame_done, ovf}), 32'd0);
        chk("rst_addr_data", 32'({DP_RAM_addr_in, DP_RAM_data_in}), 32'd0);
        chk("rst_pix_count", 32'(pix_count), 32'd0);
        chk("model_pin_f0_0f", 32'(mpix(8'hF0, 8'h0F)), 32'h0F07);
        chk("model_pin_0f_f0", 32'(mpix(8'h0F, 8'hF0)), 32'h00F8);
        mon_en = 1'b1;

        // full frame, first two lines carry fixed byte pairs
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        vblank();
        cam_line(2 * W, 1, 1'b1);
        cam_line(2 * W, 2, 1'b1);
        lines(2, H - 2, 1'b1);
        vblank();
        settle();
        chk("f1_writes", 32'(wr_n), 32'd128);
        chk("f1_frame_done", 32'(fd_cnt), 32'd1);
        chk("f1_pix_count", 32'(pix_count), 32'd128);
        chk("f1_ovf", 32'(ovf), 32'd0);
        chk("f1_last_addr", 32'(last_addr), 32'd127);
        chk("f1_data0", 32'(wd_log[0]), 32'h0F07);
        chk("f1_data16", 32'(wd_log[16]), 32'h00F8);
        chk("f1_idle", 32'(state), 32'd0);

        // start mid-frame: nothing until the next vsync high/low
        clear_logs();
        vblank();
        lines(0, 2, 1'b0);
        pulse_start();
        lines(2, H - 2, 1'b0);
        chk("mid_no_writes", 32'(wr_n), 32'd0);
        vblank();
        lines(0, H, 1'b1);
        vblank();
        settle();
        chk("mid_first_addr", 32'(wa_log[0]), 32'd0);
        chk("mid_writes", 32'(wr_n), 32'd128);
        chk("mid_frame_done", 32'(fd_cnt), 32'd1);

        // odd-length line: trailing byte dropped, next line pairs fresh
        clear_logs();
        pulse_start();
        vblank();
        cam_line(2 * W + 1, 7, 1'b1);
        lines(1, H - 1, 1'b1);
        vblank();
        settle();
        chk("odd_writes", 32'(wr_n), 32'd128);
        chk("odd_pix_count", 32'(pix_count), 32'd128);

        // one line too many
        clear_logs();
        pulse_start();
        vblank();
        lines(0, H + 1, 1'b1);
        vblank();
        settle();
        chk("ovf_model", 32'(m_ovf), 32'd1);
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_writes", 32'(wr_n), 32'd128);
        chk("ovf_last_addr", 32'(last_addr), 32'd127);
        chk("ovf_pix_count", 32'(pix_count), 32'd128);
        pulse_start();
        chk("ovf_cleared", 32'(ovf), 32'd0);
        chk("ovf_wait_vs", 32'(state), 32'd1);

        // abort after 50 pixels
        clear_logs();
        check_en = 1'b0;
        fork
            begin
                vblank();
                lines(0, H, 1'b0);
                vblank();
            end
            begin
                t = 0;
                while (wr_n < 50 && t < 20000) begin
                    @(negedge clk);
                    t++;
                end
                chk("abort_reached_50", 32'(wr_n), 32'd50);
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                chk("abort_state", 32'(state), 32'd0);
                chk("abort_regw", 32'(DP_RAM_regW), 32'd0);
            end
        join
        settle();
        chk("abort_writes", 32'(wr_n), 32'd50);
        chk("abort_no_done", 32'(fd_cnt), 32'd0);
        chk("abort_pix_count", 32'(pix_count), 32'd128);
        check_en = 1'b1;

        // continuous over two frames, dropped during the second
        clear_logs();
        continuous = 1'b1;
        vblank();
        lines(0, H, 1'b1);
        vblank();
        m_cnt = 0;
        lines(0, H / 2, 1'b1);
        continuous = 1'b0;
        lines(H / 2, H / 2, 1'b1);
        vblank();
        settle();
        chk("cont_writes", 32'(wr_n), 32'd256);
        chk("cont_frame_done", 32'(fd_cnt), 32'd2);
        chk("cont_restart_addr", 32'(wa_log[128]), 32'd0);
        chk("cont_idle", 32'(state), 32'd0);
        chk("cont_pix_count", 32'(pix_count), 32'd128);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Sequences the camera-to-framebuffer write path: arms on a start request, aligns to a frame on CAM_VSYNC, and pairs RGB565 byte pairs gated by CAM_HREF into RGB444 pixels.
- Drives the dual-port RAM write port (address, data, write strobe) and reports frame completion and errors.
- Runs entirely on the system clock. CAM_PCLK, CAM_HREF, CAM_VSYNC and CAM_px_data are sampled as ordinary inputs, synchronised, and PCLK is edge-detected.
- Sits between the camera pins and the DP RAM, replacing the free-running capture logic in test_cam.

Parameters:
IMG_W, 160, pixels per line (each pixel is two camera bytes)
IMG_H, 120, lines per frame
AW, 15, DP RAM address width (IMG_W*IMG_H must be <= 2**AW)

Ports:
clk  in  1  system clock (100 MHz); all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to capture one frame
continuous  in  1  1 = re-arm automatically after each frame
abort  in  1  return to IDLE on the next clk; no further writes
CAM_PCLK  in  1  camera pixel clock, sampled, not used as a clock
CAM_HREF  in  1  line-valid
CAM_VSYNC  in  1  frame sync (high = vertical blanking)
CAM_px_data  in  8  camera byte
DP_RAM_addr_in  out  AW  write address
DP_RAM_data_in  out  12  RGB444 pixel {R,G,B}
DP_RAM_regW  out  1  write strobe, one clk per pixel
state  out  3  current FSM state code
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-clk pulse at end of frame
pix_count  out  AW+1  pixels written in the last completed frame
ovf  out  1  sticky: pixels arrived beyond IMG_W*IMG_H; cleared by rst or start

Behaviour:
- Reset: all outputs 0, state = IDLE (0), internal address counter = 0.
- Input path: 2-flop synchroniser on PCLK, HREF, VSYNC and data, all in lockstep.
  - pclk_rise = sync_pclk & ~sync_pclk_d.
  - HREF, VSYNC and data are used only in the clk cycle where pclk_rise = 1.
- FSM codes: IDLE = 0, WAIT_VS = 1, WAIT_ACT = 2, BYTE1 = 3, BYTE2 = 4, DONE = 5.
- IDLE:
  - (start | continuous) -> WAIT_VS.
  - start also clears ovf.
- WAIT_VS: on pclk_rise with VSYNC = 1 -> WAIT_ACT. Blocks a capture from starting mid-frame.
- WAIT_ACT: on pclk_rise with VSYNC = 0 -> BYTE1; address counter <= 0.
- BYTE1: on pclk_rise with HREF = 1, latch b1 = data -> BYTE2.
- BYTE2: on pclk_rise with HREF = 1, b2 = data.
  - Pixel = {b1[7:4], b1[2:0], b2[7], b2[4:1]}.
  - Next clk: DP_RAM_regW = 1 for exactly one clk, DP_RAM_addr_in = counter, DP_RAM_data_in = pixel; counter increments.
  - Then -> BYTE1.
  - Latency from the synchronised second-byte PCLK edge to the strobe: 1 clk.
- HREF = 0 seen on pclk_rise while in BYTE2: partial pixel discarded -> BYTE1. Byte pairing restarts on every line.
- Frame end: VSYNC = 1 seen on pclk_rise in BYTE1 or BYTE2 -> DONE. Any partial pixel is discarded.
- DONE:
  - frame_done = 1 for one clk; pix_count <= counter.
  - continuous = 1 -> WAIT_ACT (VSYNC already high); otherwise -> IDLE.
- Overflow: when counter = IMG_W*IMG_H, further completed pixels produce no strobe, the counter holds, and ovf <= 1.
- Address outputs hold their last value between strobes. data_in updates only together with the strobe.
- abort, from any state:
  - Next clk: state = IDLE and regW = 0.
  - A strobe scheduled for that clk is suppressed.
  - No frame_done; pix_count unchanged.
- Priority: rst > abort > FSM. start is ignored when not in IDLE.
- continuous deasserted mid-frame: the current frame completes, then the FSM enters IDLE.

Test Plan:
- Frame of 160x120 from the standard camera model (320 bytes per line, VSYNC high for the first 2 of 4 blanking rows), start pulse -> 19200 strobes at addresses 0..19199, one frame_done, pix_count = 19200, ovf = 0.
- Byte pairs 0xF0,0x0F -> DP_RAM_data_in = 0xF07; pairs 0x0F,0xF0 -> 0x0F8; each strobe exactly 1 clk wide.
- start asserted while VSYNC is low mid-frame -> no writes until the next VSYNC high/low sequence; first write at address 0.
- Line with HREF dropped after 321 bytes (odd) -> 160 pixels written; the odd byte is discarded; the next line starts pairing fresh.
- Model sending 121 lines -> 19200 strobes, ovf = 1, last address 19199, no write at 19200; start then clears ovf.
- abort after 500 pixels -> state = 0 one clk later, no further strobes, no frame_done. continuous = 1 over 2 frames -> two frame_done pulses, addresses restart at 0.
